// File: rtl/pc_unit_ras.sv
// Program counter with a circular return-address stack.
// Priority per cycle: stall > branch > ret > call > sequential; all outputs are registered.
module pc_unit_ras #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       INSTR_BYTES  = 2,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h1040
) (
    input  logic                         inp_clk,
    input  logic                         inp_rst,
    input  logic                         inp_stall,
    input  logic                         inp_branch,
    input  logic                         inp_call,
    input  logic                         inp_ret,
    input  logic [ADDR_W-1:0]            inp_target,
    output logic [ADDR_W-1:0]            out_address,
    output logic [$clog2(RAS_DEPTH):0]   out_ras_count,
    output logic                         out_ras_overflow,
    output logic                         out_ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_en;

    assign seq_addr = pc_q + ADDR_W'(INSTR_BYTES);
    assign ptr_m1   = ptr_q - PTR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (inp_stall) begin
            pc_d = pc_q;
        end else if (inp_branch) begin
            pc_d = inp_target;
        end else if (inp_ret) begin
            if (cnt_q != '0) begin
                pc_d  = stack_q[ptr_m1];
                ptr_d = ptr_m1;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = seq_addr;
                unf_d = 1'b1;
            end
        end else if (inp_call) begin
            // ptr_q is the next write slot; on a full stack it already points at the oldest entry
            push_en = 1'b1;
            pc_d    = inp_target;
            ptr_d   = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d = seq_addr;
        end
    end

    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entries are never observed before being pushed, so the storage needs no reset
    always_ff @(posedge inp_clk) begin
        if (push_en && !inp_rst) begin
            stack_q[ptr_q] <= seq_addr;
        end
    end

    assign out_address       = pc_q;
    assign out_ras_count     = cnt_q;
    assign out_ras_overflow  = ovf_q;
    assign out_ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed scenarios followed by random traffic,
// expected state comes from a queue-based model of the PC and return stack.
module tb_pc_unit_ras;

    localparam logic [15:0] RV = 16'h1040;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] target = '0;
    logic [15:0] addr;
    logic [2:0]  cnt;
    logic        ovf, unf;

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_ovf, m_unf;

    pc_unit_ras #(
        .ADDR_W(16), .INSTR_BYTES(2), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)
    ) dut (
        .inp_clk(clk), .inp_rst(rst), .inp_stall(stall), .inp_branch(br),
        .inp_call(call), .inp_ret(ret), .inp_target(target),
        .out_address(addr), .out_ras_count(cnt),
        .out_ras_overflow(ovf), .out_ras_underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, s, b, c, t, input logic [15:0] tg);
        if (r) begin
            m_pc = RV;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (b) begin
            m_pc = tg;
        end else if (t) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc = m_pc + 16'd2;
                m_unf = 1'b1;
            end
        end else if (c) begin
            m_stack.push_back(m_pc + 16'd2);
            if (m_stack.size() > DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_pc = tg;
        end else begin
            m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic step(input logic r, s, b, c, t, input logic [15:0] tg);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; br = b; call = c; ret = t; target = tg;
        model(r, s, b, c, t, tg);
        e.pc  = m_pc;
        e.cnt = 3'(m_stack.size());
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
    endtask

    // Monitor: every cycle with a pending expectation is compared after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (addr !== e.pc) begin
                errors++;
                $display("FAIL address: got %h expected %h at %0t", addr, e.pc, $time);
            end
            checks++;
            if (cnt !== e.cnt) begin
                errors++;
                $display("FAIL ras_count: got %0d expected %0d at %0t", cnt, e.cnt, $time);
            end
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL overflow: got %b expected %b at %0t", ovf, e.ovf, $time);
            end
            checks++;
            if (unf !== e.unf) begin
                errors++;
                $display("FAIL underflow: got %b expected %b at %0t", unf, e.unf, $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;
        // Reset, idle, stall hold, release
        step(1, 0, 0, 0, 0, 16'h0);
        idle(3);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, 16'hDEAD);
        idle(1);
        // Call, idle, return
        step(0, 0, 0, 1, 0, 16'h2000);
        idle(1);
        step(0, 0, 0, 0, 1, 16'h0);
        // Five nested calls overflow, then drain and underflow
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 16'h3000 + 16'(i * 16'h100));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 16'h0);
        // Address wrap, then branch+call+ret together
        step(0, 0, 1, 0, 0, 16'hFFFE);
        idle(1);
        step(0, 0, 0, 1, 0, 16'h0500);
        step(0, 0, 1, 1, 1, 16'h0ABC);
        // Call and ret together: ret wins
        step(0, 0, 0, 1, 1, 16'h0777);
        // Reset during a call with two entries on the stack
        step(1, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 16'h4000);
        step(0, 0, 0, 1, 0, 16'h4100);
        step(1, 0, 0, 1, 0, 16'h4200);
        idle(1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 60) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                 ($urandom % 3) == 0, ($urandom % 3) == 0, 16'($urandom));
        end
        idle(2);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
